// File: rtl/cp_loader_pkg.sv
// cp_loader_pkg - shared types and helpers for the character-pixel burst loader (rev 1.0)
`default_nettype none

package cp_loader_pkg;

  localparam int QWORD_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Job lengths beyond the buffer depth are silently limited to the depth.
  function automatic int unsigned clamp_count(input int unsigned n, input int unsigned max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp_burst_loader.sv
// cp_burst_loader - fetches N qwords from SDRAM in fixed bursts and streams them into the
// character-pixel line buffer write port (rev 1.0)
`default_nettype none

module cp_burst_loader
  import cp_loader_pkg::*;
#(
  parameter  int ADDRWIDTH  = 24,
  parameter  int BURST_LEN  = 4,
  parameter  int MAX_QWORDS = 128,
  localparam int CW         = $clog2(MAX_QWORDS + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [CW-1:0]        num_qwords,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic                 sdr_req,
  output logic [ADDRWIDTH-1:0] sdr_addr,
  input  logic                 sdr_ack,
  input  logic                 sdr_valid,
  input  logic [63:0]          sdr_data,
  output logic                 cp_wr,
  output logic [63:0]          cp_data
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [ADDRWIDTH-1:0] BURST_STRIDE = ADDRWIDTH'(BURST_LEN * QWORD_BYTES);
  localparam logic [ADDRWIDTH-1:0] QWORD_MASK   = ~ADDRWIDTH'(QWORD_BYTES - 1);

  state_t                 state_q, state_nx;
  logic [ADDRWIDTH-1:0]   addr_q, addr_nx;
  logic [CW-1:0]          remaining_q, remaining_nx;
  logic [BW-1:0]          beat_q, beat_nx;
  logic                   wr_nx;
  logic                   done_nx;
  logic                   last_beat;

  assign last_beat = (beat_q == BW'(BURST_LEN - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_nx;
      addr_q      <= addr_nx;
      remaining_q <= remaining_nx;
      beat_q      <= beat_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    addr_nx      = addr_q;
    remaining_nx = remaining_q;
    beat_nx      = beat_q;
    wr_nx        = 1'b0;
    done_nx      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_qwords != '0) begin
            addr_nx      = base_addr & QWORD_MASK;
            remaining_nx = CW'(clamp_count(32'(num_qwords), MAX_QWORDS));
            state_nx     = REQ;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      REQ: begin
        // A same-cycle ack wins over cancel: the burst is owed to us and must be drained.
        if (sdr_ack) begin
          beat_nx  = '0;
          state_nx = cancel ? DRAIN : DATA;
        end else if (cancel) begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (sdr_valid) beat_nx = beat_q + BW'(1);
        if (cancel) begin
          state_nx = (sdr_valid && last_beat) ? IDLE : DRAIN;
        end else if (sdr_valid) begin
          if (remaining_q != '0) begin
            wr_nx        = 1'b1;
            remaining_nx = remaining_q - CW'(1);
          end
          if (last_beat) begin
            if (remaining_nx != '0) begin
              state_nx = REQ;
              addr_nx  = addr_q + BURST_STRIDE;
            end else begin
              state_nx = FIN;
            end
          end
        end
      end
      DRAIN: begin
        if (sdr_valid) begin
          beat_nx = beat_q + BW'(1);
          if (last_beat) state_nx = IDLE;
        end
      end
      FIN: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cp_wr   <= 1'b0;
      cp_data <= '0;
      done    <= 1'b0;
    end else begin
      cp_wr <= wr_nx;
      done  <= done_nx;
      if (wr_nx) cp_data <= sdr_data;
    end
  end

  assign busy     = (state_q != IDLE);
  assign sdr_req  = (state_q == REQ);
  assign sdr_addr = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_cp_burst_loader.sv
// tb_cp_burst_loader - directed self-checking bench for cp_burst_loader (rev 1.0)
`default_nettype none

module tb_cp_burst_loader;

  localparam int AW = 24;
  localparam int BL = 4;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_qwords = '0;
  logic          cancel = 1'b0;
  logic          busy, done, sdr_req, cp_wr;
  logic [AW-1:0] sdr_addr;
  logic          sdr_ack = 1'b0;
  logic          sdr_valid = 1'b0;
  logic [63:0]   sdr_data = '0;
  logic [63:0]   cp_data;

  cp_burst_loader #(.ADDRWIDTH(AW), .BURST_LEN(BL), .MAX_QWORDS(128)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_qwords(num_qwords), .cancel(cancel), .busy(busy), .done(done),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_ack(sdr_ack), .sdr_valid(sdr_valid),
    .sdr_data(sdr_data), .cp_wr(cp_wr), .cp_data(cp_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int unsigned beat_seq = 0;

  // Cumulative observation log, sampled on the falling edge.
  int            cyc = 0;
  int            wr_cnt = 0, req_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int            last_wr_cyc = 0, last_done_cyc = 0, start_cyc = 0;
  logic [63:0]   wr_log  [0:511];
  logic [AW-1:0] req_log [0:63];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (start) start_cyc <= cyc;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (cp_wr) begin
      if (wr_cnt < 512) wr_log[wr_cnt] <= cp_data;
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    if (sdr_req && sdr_ack) begin
      if (req_cnt < 64) req_log[req_cnt] <= sdr_addr;
      req_cnt <= req_cnt + 1;
    end
  end

  function automatic logic [63:0] pat(input int unsigned s);
    return 64'hA5C3_0000_0000_0000 | 64'(s);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [CW-1:0] n);
    tick();
    start = 1'b1; base_addr = a; num_qwords = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req();
    int t = 0;
    while (sdr_req !== 1'b1 && t < 100) begin tick(); t++; end
    check("req_seen", 64'(sdr_req), 64'd1);
  endtask

  task automatic ack_req(input int delay);
    repeat (delay) tick();
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
  endtask

  task automatic beat();
    sdr_valid = 1'b1;
    sdr_data  = pat(beat_seq);
    beat_seq++;
    tick();
    sdr_valid = 1'b0;
  endtask

  task automatic serve(input int delay, input int gap);
    wait_req();
    ack_req(delay);
    for (int b = 0; b < BL; b++) begin
      repeat (gap) tick();
      beat();
    end
  endtask

  int wb, rb, db, bb;
  int unsigned sb;

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(sdr_req), 64'd0);
    check("rst_addr", 64'(sdr_addr), 64'd0);
    check("rst_wr_data", {63'd0, cp_wr} | cp_data, 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Two bursts of four, ack two cycles after request.
    wb = wr_cnt; rb = req_cnt; db = done_cnt; sb = beat_seq;
    pulse_start(24'h001000, 8'd8);
    check("t1_req_latency", 64'(sdr_req), 64'd1);
    serve(2, 0);
    serve(2, 0);
    repeat (4) tick();
    check("t1_reqs", 64'(req_cnt - rb), 64'd2);
    check("t1_addr0", 64'(req_log[rb]), 64'h001000);
    check("t1_addr1", 64'(req_log[rb+1]), 64'h001020);
    check("t1_wr_cnt", 64'(wr_cnt - wb), 64'd8);
    for (int i = 0; i < 8; i++) check("t1_data", wr_log[wb+i], pat(sb + i));
    check("t1_done_cnt", 64'(done_cnt - db), 64'd1);
    check("t1_done_time", 64'(last_done_cyc - last_wr_cyc), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // Partial last burst: two trailing beats discarded.
    wb = wr_cnt; rb = req_cnt; db = done_cnt; sb = beat_seq;
    pulse_start(24'h004000, 8'd6);
    serve(1, 1);
    serve(0, 0);
    repeat (4) tick();
    check("t2_reqs", 64'(req_cnt - rb), 64'd2);
    check("t2_wr_cnt", 64'(wr_cnt - wb), 64'd6);
    check("t2_last_data", wr_log[wb+5], pat(sb + 5));
    check("t2_done_cnt", 64'(done_cnt - db), 64'd1);

    // Zero-length job.
    rb = req_cnt; db = done_cnt; bb = busy_cnt;
    pulse_start(24'h005000, 8'd0);
    repeat (4) tick();
    check("t3_reqs", 64'(req_cnt - rb), 64'd0);
    check("t3_done_cnt", 64'(done_cnt - db), 64'd1);
    check("t3_done_time", 64'(last_done_cyc - start_cyc), 64'd1);
    check("t3_busy_cycles", 64'(busy_cnt - bb), 64'd0);

    // Oversized job clamps to 128; unaligned base near the top of memory wraps.
    wb = wr_cnt; rb = req_cnt; db = done_cnt; sb = beat_seq;
    pulse_start(24'hFFFF05, 8'd200);
    for (int k = 0; k < 32; k++) serve(0, 0);
    repeat (6) tick();
    check("t4_reqs", 64'(req_cnt - rb), 64'd32);
    check("t4_addr_first", 64'(req_log[rb]), 64'hFFFF00);
    check("t4_addr_wrap", 64'(req_log[rb+31]), 64'h0002E0);
    check("t4_wr_cnt", 64'(wr_cnt - wb), 64'd128);
    check("t4_last_data", wr_log[wb+127], pat(sb + 127));
    check("t4_done_cnt", 64'(done_cnt - db), 64'd1);

    // Cancel after the second beat of the first burst.
    wb = wr_cnt; rb = req_cnt; db = done_cnt; sb = beat_seq;
    pulse_start(24'h002000, 8'd8);
    wait_req();
    ack_req(0);
    beat();
    beat();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    beat();
    check("t5_drain_busy", 64'(busy), 64'd1);
    beat();
    check("t5_idle_after_drain", 64'(busy), 64'd0);
    repeat (6) tick();
    check("t5_reqs", 64'(req_cnt - rb), 64'd1);
    check("t5_wr_cnt", 64'(wr_cnt - wb), 64'd2);
    check("t5_data1", wr_log[wb+1], pat(sb + 1));
    check("t5_no_done", 64'(done_cnt - db), 64'd0);

    // Second start while busy is ignored; beats arrive with gaps.
    wb = wr_cnt; rb = req_cnt; db = done_cnt;
    pulse_start(24'h003000, 8'd4);
    start = 1'b1; num_qwords = 8'd8; base_addr = 24'h00F000;
    tick();
    start = 1'b0;
    serve(1, 2);
    repeat (8) tick();
    check("t6_reqs", 64'(req_cnt - rb), 64'd1);
    check("t6_wr_cnt", 64'(wr_cnt - wb), 64'd4);
    check("t6_done_cnt", 64'(done_cnt - db), 64'd1);

    // Asynchronous reset in the middle of a data phase.
    pulse_start(24'h006000, 8'd8);
    wait_req();
    ack_req(0);
    beat();
    beat();
    reset_n = 1'b0;
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_req_addr", {39'd0, sdr_req, sdr_addr}, 64'd0);
    check("t7_wr", 64'(cp_wr), 64'd0);
    check("t7_data", cp_data, 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    wb = wr_cnt; rb = req_cnt; db = done_cnt; sb = beat_seq;
    pulse_start(24'h003008, 8'd4);
    serve(0, 0);
    repeat (4) tick();
    check("t7_fresh_addr", 64'(req_log[rb]), 64'h003008);
    check("t7_fresh_wr", 64'(wr_cnt - wb), 64'd4);
    check("t7_fresh_data0", wr_log[wb], pat(sb));
    check("t7_fresh_done", 64'(done_cnt - db), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
